// File: rtl/i2c_fclk.sv
// rtl/i2c_fclk.sv - I2C bus clock divider producing s_clk plus rise/fall strobes
module i2c_fclk #(
  parameter int CLK_HZ = 50_000_000,
  parameter int SCL_HZ = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic s_clk,
  output logic strob_up,
  output logic strob_down
);

  // clk cycles per s_clk half-period; the divide truncates on purpose
  localparam int HALF = CLK_HZ / (2 * SCL_HZ);
  localparam int CW   = (HALF < 2) ? 1 : $clog2(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  // A half-period shorter than two cycles cannot place a strobe ahead of its edge
  generate
    if (HALF < 2) begin : g_bad_half
      $error("i2c_fclk: CLK_HZ/(2*SCL_HZ) must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc = (cnt == LAST);

  // Strobes look one edge ahead: they are high in the cycle before s_clk toggles
  assign strob_up   = tc & ~s_clk;
  assign strob_down = tc & s_clk;

  // Half-period counter and bus clock flop; s_clk idles high out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      s_clk <= 1'b1;
    end else if (tc) begin
      cnt   <= '0;
      s_clk <= ~s_clk;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_i2c_fclk.sv
// tb/tb_i2c_fclk.sv - self-checking bench for i2c_fclk with a strobe scoreboard
module tb_i2c_fclk;

  localparam int HALF = 4;

  typedef struct {
    bit up;
    int cyc;
  } strobe_t;

  logic clk;
  logic rst;
  logic s_clk;
  logic strob_up;
  logic strob_down;

  strobe_t sb[$];

  int n_checks;
  int n_fail;
  int cyc;
  int n_up;
  int n_dn;
  logic prev_up;
  logic prev_dn;
  logic prev_s;

  i2c_fclk #(
    .CLK_HZ(800),
    .SCL_HZ(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_clk     (s_clk),
    .strob_up  (strob_up),
    .strob_down(strob_down)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected strobes after a release: fall at HALF, rise at 2*HALF, alternating
  task automatic push_periods(input int periods);
    strobe_t e;
    for (int i = 0; i < 2 * periods; i++) begin
      e.up  = (i % 2) == 1;
      e.cyc = HALF * (i + 1);
      sb.push_back(e);
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_s_clk", s_clk, 1);
      check("rst_up", strob_up, 0);
      check("rst_dn", strob_down, 0);
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    cyc     = 0;
    prev_up = 1'b0;
    prev_dn = 1'b0;
    prev_s  = 1'b1;
  endtask

  task automatic step(input int n);
    strobe_t e;
    logic exp_s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      exp_s = (((cyc - 1) / HALF) % 2) == 0;
      check("s_clk", s_clk, exp_s);
      check("exclusive", strob_up & strob_down, 0);
      if (prev_dn) check("fall_after_dn", {prev_s, s_clk}, 2'b10);
      if (prev_up) check("rise_after_up", {prev_s, s_clk}, 2'b01);
      if (strob_up || strob_down) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", strob_up, e.up);
          check("strobe_cycle", cyc, e.cyc);
        end
        n_up += int'(strob_up);
        n_dn += int'(strob_down);
      end
      prev_up = strob_up;
      prev_dn = strob_down;
      prev_s  = s_clk;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    n_up     = 0;
    n_dn     = 0;
    prev_up  = 1'b0;
    prev_dn  = 1'b0;
    prev_s   = 1'b1;
    rst      = 1'b0;

    // Reset held low: idle-high clock, no strobes
    hold_reset(5);

    // Release and run 100 full s_clk periods
    release_rst();
    push_periods(100);
    step(100 * 2 * HALF);
    check("sb_drained_run", sb.size(), 0);
    check("n_strob_up", n_up, 100);
    check("n_strob_down", n_dn, 100);

    // Restart cleanly, then abort during the low phase at cnt=2 (cycle 7)
    #1 rst = 1'b0;
    #1 check("async_s_clk_a", s_clk, 1);
    hold_reset(3);
    release_rst();
    begin
      strobe_t e;
      e.up  = 1'b0;
      e.cyc = HALF;
      sb.push_back(e);
    end
    step(7);
    check("pre_abort_low", s_clk, 0);
    #1 rst = 1'b0;
    #1;
    check("async_s_clk_b", s_clk, 1);
    check("async_up", strob_up, 0);
    check("async_dn", strob_down, 0);
    check("sb_drained_abort", sb.size(), 0);
    hold_reset(3);

    // Timing after the abort must match the power-up sequence exactly
    release_rst();
    push_periods(2);
    step(2 * 2 * HALF);
    check("sb_drained_restart", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
